// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock through a CHUNK-bit
// ripple stage, holding the carry in a register between chunks.
module chunked_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   int unsigned      base;
   logic [CHUNK-1:0] a_sl, b_sl, s_sl;
   logic             c_rip, c_msb;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;

      base  = 32'(cnt_q) * 32'(CHUNK);
      a_sl  = a_q[base +: CHUNK];
      b_sl  = b_q[base +: CHUNK];
      s_sl  = '0;
      c_rip = carry_q;
      c_msb = carry_q;
      // c_msb ends up holding the carry into the chunk's top bit
      for (int unsigned i = 0; i < CHUNK; i++) begin
         c_msb   = c_rip;
         s_sl[i] = a_sl[i] ^ b_sl[i] ^ c_rip;
         c_rip   = (a_sl[i] & b_sl[i]) | (c_rip & (a_sl[i] ^ b_sl[i]));
      end

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = cin ^ sub;
               sum_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[base +: CHUNK] = s_sl;
            carry_d = c_rip;
            if (cnt_q == CW'(NCHUNK - 1)) begin
               cout_d  = c_rip;
               ovf_d   = c_msb ^ c_rip;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_valid_q && out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

endmodule
